food_spawner: RTL and testbench
===============================

FOOD_SPAWNER -- requirements
Module: food_spawner

Interface
REQ-001 SHALL have parameter GRID_W, default 20, meaning playfield columns (1..32).
REQ-002 SHALL have parameter GRID_H, default 15, meaning playfield rows (1..16).
REQ-003 SHALL have parameter MAX_TRIES, default 8, meaning random candidates sampled before falling back to scan (1..15).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port spawn_req  in  1  request to place new food; accepted only in IDLE.
REQ-007 SHALL have port rng4  in  4  random row source from the LFSR stage.
REQ-008 SHALL have port rng5  in  5  random column source from the LFSR stage.
REQ-009 SHALL have port rng_update  out  1  one-cycle advance strobe to the LFSR stage.
REQ-010 SHALL have port query_valid  out  1  occupancy lookup strobe.
REQ-011 SHALL have port query_x  out  5  lookup column.
REQ-012 SHALL have port query_y  out  4  lookup row.
REQ-013 SHALL have port query_occupied  in  1  lookup result, valid exactly in the cycle after query_valid.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port done  out  1  one-cycle pulse: food placed.
REQ-016 SHALL have port fail  out  1  one-cycle pulse: no free cell exists.
REQ-017 SHALL have port food_x  out  5  placed food column.
REQ-018 SHALL have port food_y  out  4  placed food row.
REQ-019 SHALL have port food_valid  out  1  level: food_x/food_y hold a placed food.

Function
REQ-020 SHALL implement FSM states IDLE, ROLL, SAMPLE, QUERY, WAIT, SCAN_Q, SCAN_W, DONE, FAIL.
REQ-021 IDLE: spawn_req high at an edge SHALL move to ROLL, clear food_valid, clear try counter.
REQ-022 spawn_req while busy SHALL be ignored (not queued).
REQ-023 ROLL: rng_update SHALL be high for exactly this one cycle; next state SAMPLE.
REQ-024 SAMPLE: SHALL latch candidate x=rng5, y=rng4 and increment try counter.
REQ-025 SAMPLE: candidate with x>=GRID_W or y>=GRID_H SHALL be rejected without a lookup: next ROLL, or SCAN_Q with x=0,y=0 if try counter reached MAX_TRIES.
REQ-026 SAMPLE: in-range candidate SHALL go to QUERY.
REQ-027 QUERY: query_valid high one cycle with query_x/query_y = candidate; next WAIT.
REQ-028 WAIT: query_occupied low -> DONE; high -> ROLL, or SCAN_Q from (0,0) if try counter reached MAX_TRIES.
REQ-029 SCAN_Q/SCAN_W: same lookup timing as QUERY/WAIT; occupied cell advances x+1, wrapping at GRID_W-1 to x=0,y+1.
REQ-030 Scan SHALL go to FAIL after cell (GRID_W-1, GRID_H-1) is found occupied; each cell examined at most once.
REQ-031 DONE: done pulse, food_x/food_y = accepted cell, food_valid set; next IDLE.
REQ-032 FAIL: fail pulse, food_valid stays 0, food_x/food_y unchanged; next IDLE.
REQ-033 done and fail SHALL never be high together; query_valid and rng_update never high together.
REQ-034 Latency: first-try free cell -> done high in the cycle after the 4th edge following the accepting edge; each rejected out-of-range try adds 2 cycles, each occupied try adds 4.
REQ-035 query_x/query_y SHALL hold their last value when query_valid is low.

Reset
REQ-036 rst_n low SHALL immediately force IDLE and clear food_x, food_y, food_valid, busy, done, fail, rng_update, query_valid, query_x, query_y, try counter, independent of clk.
REQ-037 rst_n low mid-operation SHALL abort the spawn with no done or fail pulse; first accepted spawn_req after release behaves as from power-up.

Verification
REQ-038 Bench: rng5=15, rng4=6, occupied=0, pulse spawn_req -> one rng_update, query (15,6), done 4 edges after accept, food=(15,6), food_valid=1.
REQ-039 Bench: rng5=25 then 3, rng4=2 -> first candidate rejected with no query_valid, second queried, food=(3,2), total latency 6 edges.
REQ-040 Bench: MAX_TRIES=8, all random cells occupied, only (4,0) free -> 8 random tries then scan queries (0,0)..(4,0), food=(4,0).
REQ-041 Bench: GRID_W=4, GRID_H=2, every cell occupied -> scan visits exactly 8 cells, fail pulse, food_valid=0, done never high.
REQ-042 Bench: assert rst_n low during WAIT, release, spawn_req -> outputs at reset values immediately, no stale done, fresh spawn completes normally.
REQ-043 Bench: spawn_req held high through a whole spawn -> exactly one done per IDLE acceptance, no request queued while busy.

Source files
------------

// File: rtl/food_spawner_if.sv
// Handshake bundle between the food spawner, its LFSR source, the occupancy map and the game FSM.
// The master modport is the spawner; the slave modport is the environment around it.
interface food_spawner_if;
  logic       spawn_req;
  logic [3:0] rng4;
  logic [4:0] rng5;
  logic       rng_update;
  logic       query_valid;
  logic [4:0] query_x;
  logic [3:0] query_y;
  logic       query_occupied;
  logic       busy;
  logic       done;
  logic       fail;
  logic [4:0] food_x;
  logic [3:0] food_y;
  logic       food_valid;

  modport master (
    input  spawn_req, rng4, rng5, query_occupied,
    output rng_update, query_valid, query_x, query_y,
    output busy, done, fail, food_x, food_y, food_valid
  );

  modport slave (
    output spawn_req, rng4, rng5, query_occupied,
    input  rng_update, query_valid, query_x, query_y,
    input  busy, done, fail, food_x, food_y, food_valid
  );
endinterface

// File: rtl/food_spawner.sv
// Places food on a free playfield cell: a bounded number of random candidates,
// then a deterministic raster scan so a free cell is always found if one exists.
module food_spawner #(
  parameter int GRID_W    = 20,
  parameter int GRID_H    = 15,
  parameter int MAX_TRIES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  food_spawner_if.master bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ROLL   = 4'd1;
  localparam logic [3:0] S_SAMPLE = 4'd2;
  localparam logic [3:0] S_QUERY  = 4'd3;
  localparam logic [3:0] S_WAIT   = 4'd4;
  localparam logic [3:0] S_SCAN_Q = 4'd5;
  localparam logic [3:0] S_SCAN_W = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_FAIL   = 4'd8;

  // One extra bit so GRID_W=32 / GRID_H=16 still compare correctly against the raw RNG values.
  localparam logic [5:0] GW     = 6'(GRID_W);
  localparam logic [4:0] GH     = 5'(GRID_H);
  localparam logic [4:0] LAST_X = 5'(GRID_W - 1);
  localparam logic [3:0] LAST_Y = 4'(GRID_H - 1);
  localparam logic [3:0] TRIES  = 4'(MAX_TRIES);

  logic [3:0] state_q, state_d;
  logic [3:0] try_q, try_d;
  logic [4:0] cand_x_q, cand_x_d;
  logic [3:0] cand_y_q, cand_y_d;
  logic [4:0] query_x_q, query_x_d;
  logic [3:0] query_y_q, query_y_d;
  logic [4:0] food_x_q, food_x_d;
  logic [3:0] food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;
  logic [3:0] try_inc;
  logic       cand_oob;

  always_comb begin
    state_d      = state_q;
    try_d        = try_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    query_x_d    = query_x_q;
    query_y_d    = query_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    try_inc      = try_q + 4'd1;
    cand_oob     = ({1'b0, bus.rng5} >= GW) || ({1'b0, bus.rng4} >= GH);

    case (state_q)
      S_IDLE: begin
        if (bus.spawn_req) begin
          state_d      = S_ROLL;
          food_valid_d = 1'b0;
          try_d        = 4'd0;
        end
      end
      S_ROLL: state_d = S_SAMPLE;
      S_SAMPLE: begin
        cand_x_d = bus.rng5;
        cand_y_d = bus.rng4;
        try_d    = try_inc;
        if (!cand_oob) begin
          state_d   = S_QUERY;
          query_x_d = bus.rng5;
          query_y_d = bus.rng4;
        end else if (try_inc >= TRIES) begin
          state_d   = S_SCAN_Q;
          cand_x_d  = 5'd0;
          cand_y_d  = 4'd0;
          query_x_d = 5'd0;
          query_y_d = 4'd0;
        end else begin
          state_d = S_ROLL;
        end
      end
      S_QUERY: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.query_occupied) begin
          state_d      = S_DONE;
          food_x_d     = cand_x_q;
          food_y_d     = cand_y_q;
          food_valid_d = 1'b1;
        end else if (try_q >= TRIES) begin
          state_d   = S_SCAN_Q;
          cand_x_d  = 5'd0;
          cand_y_d  = 4'd0;
          query_x_d = 5'd0;
          query_y_d = 4'd0;
        end else begin
          state_d = S_ROLL;
        end
      end
      S_SCAN_Q: state_d = S_SCAN_W;
      S_SCAN_W: begin
        if (!bus.query_occupied) begin
          state_d      = S_DONE;
          food_x_d     = cand_x_q;
          food_y_d     = cand_y_q;
          food_valid_d = 1'b1;
        end else if (cand_x_q == LAST_X && cand_y_q == LAST_Y) begin
          state_d = S_FAIL;
        end else begin
          if (cand_x_q == LAST_X) begin
            cand_x_d = 5'd0;
            cand_y_d = cand_y_q + 4'd1;
          end else begin
            cand_x_d = cand_x_q + 5'd1;
          end
          query_x_d = cand_x_d;
          query_y_d = cand_y_d;
          state_d   = S_SCAN_Q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      try_q        <= 4'd0;
      cand_x_q     <= 5'd0;
      cand_y_q     <= 4'd0;
      query_x_q    <= 5'd0;
      query_y_q    <= 4'd0;
      food_x_q     <= 5'd0;
      food_y_q     <= 4'd0;
      food_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      try_q        <= try_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      query_x_q    <= query_x_d;
      query_y_q    <= query_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them with it.
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rng_update  = (state_q == S_ROLL);
  assign bus.query_valid = (state_q == S_QUERY) || (state_q == S_SCAN_Q);
  assign bus.done        = (state_q == S_DONE);
  assign bus.fail        = (state_q == S_FAIL);
  assign bus.query_x     = query_x_q;
  assign bus.query_y     = query_y_q;
  assign bus.food_x      = food_x_q;
  assign bus.food_y      = food_y_q;
  assign bus.food_valid  = food_valid_q;

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: directed scenarios plus randomized grids, each spawn
// compared against a try-by-try outcome model of the placement rules.
module tb_food_spawner;

  localparam int GW    = 20;
  localparam int GH    = 15;
  localparam int TRIES = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  food_spawner_if bus ();
  food_spawner_if sbus ();

  food_spawner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  food_spawner #(.GRID_W(4), .GRID_H(2), .MAX_TRIES(8)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.master)
  );

  int checks = 0;
  int errors = 0;

  bit occ [0:31][0:15];
  int cand_x [0:15];
  int cand_y [0:15];

  int rng_total = 0, rng_base = 0, query_total = 0;
  int done_total = 0, fail_total = 0, overlap_total = 0;
  int q_log [$];
  int s_queries = 0, s_done = 0, s_fail = 0;
  int s_log [$];
  int exp_food_x = 0, exp_food_y = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // LFSR stand-in and event monitor: new candidate presented on each rng_update strobe.
  initial begin
    int k;
    bus.rng5 = 5'd0;
    bus.rng4 = 4'd0;
    forever begin
      @(negedge clk);
      if (bus.rng_update === 1'b1) begin
        k = rng_total - rng_base;
        if (k > 15) k = 15;
        bus.rng5 = 5'(cand_x[k]);
        bus.rng4 = 4'(cand_y[k]);
        rng_total++;
      end
      if (bus.query_valid === 1'b1) begin
        query_total++;
        q_log.push_back(int'(bus.query_y) * 32 + int'(bus.query_x));
      end
      if (bus.done === 1'b1) done_total++;
      if (bus.fail === 1'b1) fail_total++;
      if ((bus.done && bus.fail) || (bus.query_valid && bus.rng_update)) overlap_total++;
      if (sbus.query_valid === 1'b1) begin
        s_queries++;
        s_log.push_back(int'(sbus.query_y) * 32 + int'(sbus.query_x));
      end
      if (sbus.done === 1'b1) s_done++;
      if (sbus.fail === 1'b1) s_fail++;
      if ((sbus.done && sbus.fail) || (sbus.query_valid && sbus.rng_update)) overlap_total++;
    end
  end

  // Occupancy map: answer is driven only during the cycle after query_valid.
  initial begin
    logic [4:0] qx;
    logic [3:0] qy;
    bus.query_occupied = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.query_valid === 1'b1) begin
        qx = bus.query_x;
        qy = bus.query_y;
        @(posedge clk);
        #1 bus.query_occupied = occ[qx][qy];
        @(posedge clk);
        #1 bus.query_occupied = 1'b0;
      end
    end
  end

  task automatic model_spawn(output logic d, output int fx, fy, edges, nq, nr);
    d = 1'b0; fx = 0; fy = 0; edges = 0; nq = 0; nr = 0;
    for (int t = 0; t < TRIES && !d; t++) begin
      nr++;
      if (cand_x[t] >= GW || cand_y[t] >= GH) edges += 2;
      else begin
        edges += 4;
        nq++;
        if (!occ[cand_x[t]][cand_y[t]]) begin d = 1'b1; fx = cand_x[t]; fy = cand_y[t]; end
      end
    end
    for (int y = 0; y < GH && !d; y++)
      for (int x = 0; x < GW && !d; x++) begin
        edges += 2;
        nq++;
        if (!occ[x][y]) begin d = 1'b1; fx = x; fy = y; end
      end
  endtask

  task automatic applyStimulus(input bit hold, output int edges, output logic got_done, output logic got_fail);
    edges = 0; got_done = 1'b0; got_fail = 1'b0;
    bus.spawn_req = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.spawn_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.done === 1'b1 || bus.fail === 1'b1) begin
        got_done = bus.done;
        got_fail = bus.fail;
        break;
      end
    end
    @(negedge clk);
    bus.spawn_req = 1'b0;
  endtask

  task automatic spawn_and_check(input string tag, input bit hold, output int q_base);
    int edges, ex, ey, e_edges, e_q, e_r, r0, q0, d0, f0;
    logic got_done, got_fail, e_done;
    rng_base = rng_total;
    q_base = q_log.size();
    r0 = rng_total; q0 = query_total; d0 = done_total; f0 = fail_total;
    model_spawn(e_done, ex, ey, e_edges, e_q, e_r);
    applyStimulus(hold, edges, got_done, got_fail);
    repeat (6) @(negedge clk);
    if (e_done) begin exp_food_x = ex; exp_food_y = ey; end
    checkOutput({tag, " done"}, 32'(got_done), 32'(e_done));
    checkOutput({tag, " fail"}, 32'(got_fail), 32'(!e_done));
    checkOutput({tag, " latency"}, 32'(edges), 32'(e_edges));
    checkOutput({tag, " food_valid"}, 32'(bus.food_valid), 32'(e_done));
    checkOutput({tag, " food_x"}, 32'(bus.food_x), 32'(exp_food_x));
    checkOutput({tag, " food_y"}, 32'(bus.food_y), 32'(exp_food_y));
    checkOutput({tag, " queries"}, 32'(query_total - q0), 32'(e_q));
    checkOutput({tag, " rng_updates"}, 32'(rng_total - r0), 32'(e_r));
    checkOutput({tag, " done pulses"}, 32'(done_total - d0), 32'(int'(e_done)));
    checkOutput({tag, " fail pulses"}, 32'(fail_total - f0), 32'(int'(!e_done)));
    checkOutput({tag, " idle after"}, 32'(bus.busy), 32'(0));
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'(0));
    checkOutput({tag, " done"}, 32'(bus.done), 32'(0));
    checkOutput({tag, " fail"}, 32'(bus.fail), 32'(0));
    checkOutput({tag, " rng_update"}, 32'(bus.rng_update), 32'(0));
    checkOutput({tag, " query_valid"}, 32'(bus.query_valid), 32'(0));
    checkOutput({tag, " query_xy"}, 32'({bus.query_y, bus.query_x}), 32'(0));
    checkOutput({tag, " food_xy"}, 32'({bus.food_y, bus.food_x}), 32'(0));
    checkOutput({tag, " food_valid"}, 32'(bus.food_valid), 32'(0));
  endtask

  task automatic set_occ(input bit value);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 16; y++)
        occ[x][y] = value;
  endtask

  initial begin
    int qb, edges, d0, f0, sb, sq0, sd0, sf0;
    bit seen, got;
    bus.spawn_req = 1'b0;
    sbus.spawn_req = 1'b0;
    sbus.rng5 = 5'd2;
    sbus.rng4 = 4'd1;
    sbus.query_occupied = 1'b1;
    for (int i = 0; i < 16; i++) begin cand_x[i] = 0; cand_y[i] = 0; end
    set_occ(1'b0);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("power-up");
    rst_n = 1'b1;
    @(negedge clk);

    // Free first candidate.
    cand_x[0] = 15; cand_y[0] = 6;
    spawn_and_check("first-try", 1'b0, qb);
    checkOutput("first-try query cell", 32'(q_log[qb]), 32'(6 * 32 + 15));

    // Out-of-range column rejected without a lookup.
    cand_x[0] = 25; cand_y[0] = 2; cand_x[1] = 3; cand_y[1] = 2;
    spawn_and_check("oob-retry", 1'b0, qb);
    checkOutput("oob-retry query cell", 32'(q_log[qb]), 32'(2 * 32 + 3));

    // All random picks occupied; only (4,0) free, found by the scan.
    set_occ(1'b1);
    occ[4][0] = 1'b0;
    for (int t = 0; t < 8; t++) begin cand_x[t] = 10 + t; cand_y[t] = 5; end
    spawn_and_check("scan-find", 1'b0, qb);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("scan-find cell %0d", i), 32'(q_log[qb + 8 + i]), 32'(i));

    // Tiny fully occupied grid must fail after scanning each cell once.
    sq0 = s_queries; sd0 = s_done; sf0 = s_fail; sb = s_log.size();
    sbus.spawn_req = 1'b1;
    @(posedge clk);
    #1 sbus.spawn_req = 1'b0;
    edges = 0; got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (sbus.fail === 1'b1 || sbus.done === 1'b1) got = 1'b1;
    end
    repeat (4) @(negedge clk);
    checkOutput("small latency", 32'(edges), 32'(48));
    checkOutput("small queries", 32'(s_queries - sq0), 32'(16));
    checkOutput("small fail pulses", 32'(s_fail - sf0), 32'(1));
    checkOutput("small done pulses", 32'(s_done - sd0), 32'(0));
    checkOutput("small food_valid", 32'(sbus.food_valid), 32'(0));
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("small scan cell %0d", i), 32'(s_log[sb + 8 + i]), 32'((i / 4) * 32 + (i % 4)));

    // Reset asserted while a lookup answer is pending.
    set_occ(1'b0);
    cand_x[0] = 7; cand_y[0] = 3;
    rng_base = rng_total;
    bus.spawn_req = 1'b1;
    @(posedge clk);
    #1 bus.spawn_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.query_valid === 1'b1) seen = 1'b1;
    end
    checkOutput("abort query seen", 32'(seen), 32'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    d0 = done_total; f0 = fail_total;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("abort no done", 32'(done_total - d0), 32'(0));
    checkOutput("abort no fail", 32'(fail_total - f0), 32'(0));
    exp_food_x = 0; exp_food_y = 0;
    spawn_and_check("after-abort", 1'b0, qb);

    // Request held high: one occupied try, then success, no second spawn.
    occ[9][9] = 1'b1;
    cand_x[0] = 9; cand_y[0] = 9; cand_x[1] = 9; cand_y[1] = 10;
    spawn_and_check("held-req", 1'b1, qb);

    for (int it = 0; it < 12; it++) begin
      for (int x = 0; x < 32; x++)
        for (int y = 0; y < 16; y++)
          occ[x][y] = ($urandom_range(0, 3) != 0);
      if (it == 3) set_occ(1'b1);
      for (int t = 0; t < 16; t++) begin
        cand_x[t] = $urandom_range(0, 31);
        cand_y[t] = $urandom_range(0, 15);
      end
      spawn_and_check($sformatf("random %0d", it), 1'b0, qb);
    end

    checkOutput("exclusive strobes", 32'(overlap_total), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
